// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// Shares the single register-file write port between two writeback requesters.
// Each requester fills its own DEPTH-entry FIFO through a valid/ready handshake.
// A round-robin arbiter drains the FIFOs into a registered write stage, with at
// most one register-file write per cycle. Read-after-write hazards are flagged
// for the two read ports while a write to the read register is queued or issuing.
//
// Ports
//   clk, clr                      clock, synchronous active-high reset
//   in0_valid/ready/wn/d          requester 0 push handshake and payload
//   in1_valid/ready/wn/d          requester 1 push handshake and payload
//   rf_we, rf_wn, rf_d            registered register-file write port
//   rna, rnb                      read port register numbers
//   hza, hzb                      hazard flags for rna / rnb
//   idle                          both FIFOs empty and no write issuing
module rf_write_arbiter #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          in0_valid,
    output logic          in0_ready,
    input  logic [AW-1:0] in0_wn,
    input  logic [DW-1:0] in0_d,
    input  logic          in1_valid,
    output logic          in1_ready,
    input  logic [AW-1:0] in1_wn,
    input  logic [DW-1:0] in1_d,
    output logic          rf_we,
    output logic [AW-1:0] rf_wn,
    output logic [DW-1:0] rf_d,
    input  logic [AW-1:0] rna,
    input  logic [AW-1:0] rnb,
    output logic          hza,
    output logic          hzb,
    output logic          idle
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [AW-1:0] wn_q  [2][DEPTH];
    logic [DW-1:0] dat_q [2][DEPTH];
    logic [PW-1:0] wp_q  [2];
    logic [PW-1:0] rp_q  [2];
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic [1:0]    rdy_q;
    logic          last_q;
    logic          rf_we_q;
    logic [AW-1:0] rf_wn_q;
    logic [DW-1:0] rf_d_q;

    logic [1:0]    in_valid;
    logic [AW-1:0] in_wn [2];
    logic [DW-1:0] in_d  [2];
    logic [1:0]    push;
    logic [1:0]    ne;
    logic [1:0]    gnt;
    logic [AW-1:0] head_wn;
    logic [DW-1:0] head_d;
    logic          occ [2][DEPTH];

    assign in_valid = {in1_valid, in0_valid};
    assign in_wn[0] = in0_wn;
    assign in_wn[1] = in1_wn;
    assign in_d[0]  = in0_d;
    assign in_d[1]  = in1_d;

    assign ne[0] = (cnt_q[0] != '0);
    assign ne[1] = (cnt_q[1] != '0);

    // last_q names the most recent winner; on a tie the other side wins.
    assign gnt[0] = ne[0] & (~ne[1] | last_q);
    assign gnt[1] = ne[1] & (~ne[0] | ~last_q);

    // Ready comes from the registered count only, so a full FIFO refuses a push
    // even in a cycle where it is also popping.
    assign push = in_valid & rdy_q;

    assign head_wn = gnt[0] ? wn_q[0][rp_q[0]]  : wn_q[1][rp_q[1]];
    assign head_d  = gnt[0] ? dat_q[0][rp_q[0]] : dat_q[1][rp_q[1]];

    always_comb begin
        for (int r = 0; r < 2; r++) begin
            cnt_d[r] = cnt_q[r] + CW'(push[r]) - CW'(gnt[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int r = 0; r < 2; r++) begin
                wp_q[r]  <= '0;
                rp_q[r]  <= '0;
                cnt_q[r] <= '0;
            end
            rdy_q   <= 2'b11;
            last_q  <= 1'b1;
            rf_we_q <= 1'b0;
            rf_wn_q <= '0;
            rf_d_q  <= '0;
        end else begin
            for (int r = 0; r < 2; r++) begin
                if (push[r]) begin
                    wn_q[r][wp_q[r]]  <= in_wn[r];
                    dat_q[r][wp_q[r]] <= in_d[r];
                    wp_q[r]           <= wp_q[r] + 1'b1;
                end
                if (gnt[r]) begin
                    rp_q[r] <= rp_q[r] + 1'b1;
                end
                cnt_q[r] <= cnt_d[r];
                rdy_q[r] <= (cnt_d[r] != CW'(DEPTH));
            end
            if (|gnt) begin
                last_q  <= gnt[1];
                rf_wn_q <= head_wn;
                rf_d_q  <= head_d;
                // r0 writes use up the slot but never strobe the register file.
                rf_we_q <= (head_wn != '0);
            end else begin
                rf_we_q <= 1'b0;
            end
        end
    end

    // An entry is occupied when its distance from the read pointer, modulo
    // DEPTH, is below the occupancy count.
    always_comb begin
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                occ[r][i] = (CW'(PW'(i) - rp_q[r]) < cnt_q[r]);
            end
        end
    end

    always_comb begin
        hza = rf_we_q & (rf_wn_q == rna);
        hzb = rf_we_q & (rf_wn_q == rnb);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (occ[r][i] && (wn_q[r][i] == rna)) hza = 1'b1;
                if (occ[r][i] && (wn_q[r][i] == rnb)) hzb = 1'b1;
            end
        end
        hza = hza & (rna != '0);
        hzb = hzb & (rnb != '0);
    end

    assign in0_ready = rdy_q[0];
    assign in1_ready = rdy_q[1];
    assign rf_we     = rf_we_q;
    assign rf_wn     = rf_wn_q;
    assign rf_d      = rf_d_q;
    assign idle      = ~ne[0] & ~ne[1] & ~rf_we_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        clr;
    logic        in0_valid, in0_ready;
    logic [4:0]  in0_wn;
    logic [31:0] in0_d;
    logic        in1_valid, in1_ready;
    logic [4:0]  in1_wn;
    logic [31:0] in1_d;
    logic        rf_we;
    logic [4:0]  rf_wn;
    logic [31:0] rf_d;
    logic [4:0]  rna, rnb;
    logic        hza, hzb, idle;

    int errors = 0;
    int checks = 0;

    logic [31:0] rf_mem [32] = '{default: 32'h0};
    logic [4:0]  log_wn [64];
    logic [31:0] log_d  [64];
    int          log_n = 0;

    rf_write_arbiter #(.DEPTH(2), .AW(5), .DW(32)) dut (
        .clk(clk), .clr(clr),
        .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_wn(in0_wn), .in0_d(in0_d),
        .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_wn(in1_wn), .in1_d(in1_d),
        .rf_we(rf_we), .rf_wn(rf_wn), .rf_d(rf_d),
        .rna(rna), .rnb(rnb), .hza(hza), .hzb(hzb), .idle(idle)
    );

    always #5 clk = ~clk;

    // Register-file model plus a log of every committed write.
    always @(posedge clk) begin
        if (rf_we) begin
            rf_mem[rf_wn] <= rf_d;
            if (log_n < 64) begin
                log_wn[log_n] <= rf_wn;
                log_d[log_n]  <= rf_d;
                log_n         <= log_n + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (!idle && n < budget) begin
            tick();
            n++;
        end
        chk(tag, {31'b0, idle}, 32'd1);
    endtask

    initial begin
        int base;
        int ia, ib;
        logic a0, a1;
        logic [4:0]  exp_wn [7];
        logic [31:0] exp_d  [7];

        clr = 1'b1;
        in0_valid = 1'b0; in0_wn = '0; in0_d = '0;
        in1_valid = 1'b0; in1_wn = '0; in1_d = '0;
        rna = 5'd1; rnb = 5'd2;
        tick();
        tick();
        clr = 1'b0;
        chk("rst_rf_we", {31'b0, rf_we}, 32'd0);
        chk("rst_rf_wn", {27'b0, rf_wn}, 32'd0);
        chk("rst_rf_d", rf_d, 32'd0);
        chk("rst_ready0", {31'b0, in0_ready}, 32'd1);
        chk("rst_ready1", {31'b0, in1_ready}, 32'd1);
        chk("rst_hza", {31'b0, hza}, 32'd0);
        chk("rst_hzb", {31'b0, hzb}, 32'd0);
        chk("rst_idle", {31'b0, idle}, 32'd1);

        // First tie after reset: requester 0 wins.
        rna = 5'd2; rnb = 5'd3;
        in0_valid = 1'b1; in0_wn = 5'd2; in0_d = 32'h22;
        in1_valid = 1'b1; in1_wn = 5'd3; in1_d = 32'h33;
        tick();
        in0_valid = 1'b0; in1_valid = 1'b0;
        chk("tie1_hza_queued", {31'b0, hza}, 32'd1);
        chk("tie1_hzb_queued", {31'b0, hzb}, 32'd1);
        chk("tie1_we_before", {31'b0, rf_we}, 32'd0);
        tick();
        chk("tie1_first_we", {31'b0, rf_we}, 32'd1);
        chk("tie1_first_wn", {27'b0, rf_wn}, 32'd2);
        chk("tie1_first_d", rf_d, 32'h22);
        tick();
        chk("tie1_second_wn", {27'b0, rf_wn}, 32'd3);
        chk("tie1_second_d", rf_d, 32'h33);
        chk("tie1_hza_after_commit", {31'b0, hza}, 32'd0);
        chk("tie1_hzb_issuing", {31'b0, hzb}, 32'd1);
        tick();
        chk("tie1_hzb_after_commit", {31'b0, hzb}, 32'd0);
        chk("tie1_idle", {31'b0, idle}, 32'd1);

        // Single uncontended write.
        rna = 5'd1;
        in0_valid = 1'b1; in0_wn = 5'd1; in0_d = 32'h1;
        tick();
        in0_valid = 1'b0;
        chk("single_hza_queued", {31'b0, hza}, 32'd1);
        chk("single_idle_busy", {31'b0, idle}, 32'd0);
        chk("single_we_before", {31'b0, rf_we}, 32'd0);
        tick();
        chk("single_we", {31'b0, rf_we}, 32'd1);
        chk("single_wn", {27'b0, rf_wn}, 32'd1);
        chk("single_d", rf_d, 32'd1);
        chk("single_hza_issuing", {31'b0, hza}, 32'd1);
        tick();
        chk("single_we_drop", {31'b0, rf_we}, 32'd0);
        chk("single_hza_clear", {31'b0, hza}, 32'd0);
        chk("single_idle", {31'b0, idle}, 32'd1);
        chk("single_rf_r1", rf_mem[1], 32'd1);

        // Second tie: requester 0 won last, so requester 1 goes first.
        in0_valid = 1'b1; in0_wn = 5'd6; in0_d = 32'h66;
        in1_valid = 1'b1; in1_wn = 5'd7; in1_d = 32'h77;
        tick();
        in0_valid = 1'b0; in1_valid = 1'b0;
        tick();
        chk("tie2_first_wn", {27'b0, rf_wn}, 32'd7);
        chk("tie2_first_d", rf_d, 32'h77);
        tick();
        chk("tie2_second_wn", {27'b0, rf_wn}, 32'd6);
        chk("tie2_second_d", rf_d, 32'h66);
        wait_idle("tie2_idle", 10);

        // r0 write: pops, loads wn/d, no strobe.
        rna = 5'd0;
        base = log_n;
        in0_valid = 1'b1; in0_wn = 5'd0; in0_d = 32'hFFFF_FFFF;
        tick();
        in0_valid = 1'b0;
        chk("r0_hza", {31'b0, hza}, 32'd0);
        chk("r0_idle_busy", {31'b0, idle}, 32'd0);
        tick();
        chk("r0_we", {31'b0, rf_we}, 32'd0);
        chk("r0_wn", {27'b0, rf_wn}, 32'd0);
        chk("r0_d", rf_d, 32'hFFFF_FFFF);
        chk("r0_idle", {31'b0, idle}, 32'd1);
        tick();
        chk("r0_no_commit", log_n - base, 32'd0);

        // Reset with writes queued in both FIFOs.
        rna = 5'd24; rnb = 5'd27;
        in0_valid = 1'b1; in0_wn = 5'd24; in0_d = 32'h240;
        in1_valid = 1'b1; in1_wn = 5'd26; in1_d = 32'h260;
        tick();
        in0_wn = 5'd25; in0_d = 32'h250;
        in1_wn = 5'd27; in1_d = 32'h270;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_rf_we", {31'b0, rf_we}, 32'd0);
        chk("clr_rf_wn", {27'b0, rf_wn}, 32'd0);
        chk("clr_rf_d", rf_d, 32'd0);
        chk("clr_ready0", {31'b0, in0_ready}, 32'd1);
        chk("clr_ready1", {31'b0, in1_ready}, 32'd1);
        chk("clr_idle", {31'b0, idle}, 32'd1);
        chk("clr_hza", {31'b0, hza}, 32'd0);
        chk("clr_hzb", {31'b0, hzb}, 32'd0);
        in0_valid = 1'b0; in1_valid = 1'b0;
        tick(); tick(); tick();
        chk("clr_r24_dropped", rf_mem[24], 32'd0);
        chk("clr_r25_dropped", rf_mem[25], 32'd0);
        chk("clr_r27_dropped", rf_mem[27], 32'd0);
        chk("clr_r26_issued", rf_mem[26], 32'h260);
        chk("clr_idle_after", {31'b0, idle}, 32'd1);

        // Backpressure: in0 streams 4 writes, in1 pushes 3 back-to-back.
        base = log_n;
        ia = 0; ib = 0;
        for (int c = 0; c < 40 && !(ia == 4 && ib == 3); c++) begin
            in0_valid = (ia < 4); in0_wn = 5'(20 + ia); in0_d = 32'hA0 + 32'(ia);
            in1_valid = (ib < 3); in1_wn = 5'(10 + ib); in1_d = 32'hB0 + 32'(ib);
            a0 = in0_valid && in0_ready;
            a1 = in1_valid && in1_ready;
            tick();
            if (a0) ia++;
            if (a1) begin
                ib++;
                if (ib == 2) chk("bp_in1_ready_full", {31'b0, in1_ready}, 32'd0);
            end
        end
        in0_valid = 1'b0; in1_valid = 1'b0;
        chk("bp_in0_accepts", ia, 32'd4);
        chk("bp_in1_accepts", ib, 32'd3);
        wait_idle("bp_idle", 20);
        chk("bp_commit_count", log_n - base, 32'd7);
        exp_wn = '{5'd20, 5'd10, 5'd21, 5'd11, 5'd22, 5'd12, 5'd23};
        exp_d  = '{32'hA0, 32'hB0, 32'hA1, 32'hB1, 32'hA2, 32'hB2, 32'hA3};
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("bp_order_wn%0d", k), {27'b0, log_wn[base + k]}, {27'b0, exp_wn[k]});
            chk($sformatf("bp_order_d%0d", k), log_d[base + k], exp_d[k]);
        end

        // Same register from both requesters on consecutive cycles.
        rna = 5'd5;
        in0_valid = 1'b1; in0_wn = 5'd5; in0_d = 32'd1;
        tick();
        in0_valid = 1'b0;
        in1_valid = 1'b1; in1_wn = 5'd5; in1_d = 32'd2;
        tick();
        in1_valid = 1'b0;
        chk("same_hza_pending", {31'b0, hza}, 32'd1);
        wait_idle("same_idle", 10);
        chk("same_r5_final", rf_mem[5], 32'd2);
        chk("same_hza_clear", {31'b0, hza}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
